r512x16_rd_streamer: RTL
========================

# r512x16_rd_streamer

Read-side sequencer for the 512x16 inferred RAM. It accepts a burst command (start address, length), drives the RAM read port one address per cycle, and compensates for the RAM's one-cycle registered read latency. It returns the words as a valid/ready stream with a last-beat marker, using a small credit-controlled skid FIFO so that downstream backpressure never loses in-flight data. It sits directly on the RAM's RA/RD port, between the RAM and the downstream consumer.

## Interface
- ADDR_W, 9, RAM address width
- DATA_W, 16, RAM/stream data width
- LEN_W, 10, burst length width (max 512)
- FIFO_D, 3, skid FIFO depth (minimum for 1 word/cycle without a combinational ready path)

Ports:
- Clk  in  1  single clock; also drives the RAM's RClk
- Rst_n  in  1  asynchronous, active-low reset
- Cmd_Valid  in  1  command offered
- Cmd_Ready  out  1  high only in IDLE; reset value 1 after reset release
- Cmd_Addr  in  ADDR_W  burst start address
- Cmd_Len  in  LEN_W  word count, 0..512
- RA  out  ADDR_W  RAM read address; reset value 0
- RClk_En  out  1  read-issue strobe to the RAM; reset value 0
- RD  in  DATA_W  RAM read data, valid the cycle after issue
- Out_Valid  out  1  stream data valid; reset value 0
- Out_Ready  in  1  consumer accepts
- Out_Data  out  DATA_W  stream word; reset value 0
- Out_Last  out  1  final word of burst; reset value 0
- Busy  out  1  state is not IDLE; reset value 0
- Done  out  1  one-cycle pulse when a burst completes; reset value 0

## Operation
- States:
  - IDLE: Cmd_Ready=1. A Cmd_Valid&Cmd_Ready handshake latches the address and the remaining count. Len=0 → remain in IDLE, no reads, Done=1 in the next cycle. Len≥1 → ISSUE.
  - ISSUE: a read is issued in a cycle (RClk_En=1, RA=current address) iff fifo_count+inflight < FIFO_D. Each issue advances the address mod 512 (511→0) and decrements the remaining count. The last issue → DRAIN.
  - DRAIN: no issues. When the last-tagged word handshakes on the output → IDLE, and Done=1 the following cycle.
- inflight: 1-bit register, set on issue. In the next cycle, RD is pushed into the FIFO together with a last tag (1 iff that issue was the final one).
- Out_Valid, Out_Data, Out_Last reflect the FIFO head. Push and pop in the same cycle are allowed. The credit rule guarantees the FIFO never overflows.
- Out_Valid never deasserts, and Out_Data/Out_Last never change, while Out_Valid=1 and Out_Ready=0.
- Cmd_Valid outside IDLE is ignored (not accepted).
- Rst_n low at any time: immediate return to IDLE. FIFO is emptied, inflight is cleared, all outputs take their reset values, and the partial burst is discarded with no Done.

## Timing
- Handshake at edge E0 → RA=Cmd_Addr, RClk_En=1 during cycle E0..E1 → RD valid after E1 → FIFO push at E2 → Out_Valid=1 after E2. First-word latency is 2 cycles.
- With Out_Ready held high: one word per cycle. A burst of N words occupies Out_Valid for N consecutive cycles.
- Done rises the cycle after the Out_Last handshake. Cmd_Ready is 1 in that same cycle, so back-to-back bursts have a 1-cycle bubble plus the 2-cycle latency.
- Out_Ready low: issue stops once fifo_count+inflight = 3. Resumes one cycle after Out_Ready returns high. No word is dropped or duplicated.

## Structure
- Shared package r512x16_pkg:
  - ADDR_W, DATA_W, LEN_W, DEPTH=512
  - state enum {IDLE, ISSUE, DRAIN}
- Sub-module rd_skid_fifo:
  - FIFO_D entries of {last, data}
  - count output, registered head
  - same Clk/Rst_n
- Top holds the FSM, address/remaining counters, and inflight/credit logic.

## Test plan
- RAM preloaded mem[i]=i; Cmd Addr=0x010 Len=4, Out_Ready=1 → Out_Data 0x0010..0x0013 on 4 consecutive cycles starting 2 cycles after accept; Out_Last on 0x0013; Done one cycle later.
- Addr=0x1FE Len=4 → RA sequence 0x1FE,0x1FF,0x000,0x001; data 0x01FE,0x01FF,0x0000,0x0001.
- Len=8 with Out_Ready toggling 1,0,0,1,0,…: all 8 words delivered in order, no loss or duplicates. Never more than 3 outstanding (fifo_count+inflight ≤ 3). Out_Data stable while stalled.
- Len=0 → Cmd_Ready stays 1, RClk_En never asserts, Done pulses once the next cycle.
- Len=512 from Addr=0x100, Out_Ready=1 → 512 words wrapping through 0x000, exactly one Out_Last; Cmd_Valid held high during the burst is not accepted until IDLE.
- Rst_n pulsed low mid-burst with FIFO holding 2 words → Out_Valid=0, Busy=0, Cmd_Ready=1 immediately. No Done. A new burst then runs correctly.

Source files
------------

// File: rtl/r512x16_pkg.sv
// r512x16_pkg: shared widths, FSM states and credit helper for the 512x16 read streamer
package r512x16_pkg;
    localparam int DEPTH  = 512;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int DATA_W = 16;
    localparam int LEN_W  = 10;
    localparam int FIFO_D = 3;
    localparam int CNT_W  = $clog2(FIFO_D + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    function automatic logic has_credit(input logic [CNT_W-1:0] cnt, input logic inflight);
        return (int'(cnt) + int'(inflight)) < FIFO_D;
    endfunction
endpackage

// File: rtl/rd_skid_fifo.sv
// rd_skid_fifo: small shift-register FIFO of {last, data}; entry 0 is the registered head
module rd_skid_fifo
    import r512x16_pkg::*;
#(
    parameter int W  = DATA_W + 1,
    parameter int D  = FIFO_D,
    parameter int CW = CNT_W
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic [CW-1:0] o_count
);
    logic [W-1:0]  r_mem [D];
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_wr_idx;

    assign w_wr_idx = r_cnt - CW'(i_pop);
    assign o_head   = r_mem[0];
    assign o_count  = r_cnt;

    // shift toward the head on pop; a push lands just behind the surviving entries
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt <= '0;
            for (int i = 0; i < D; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < D - 1; i++) if (i_pop) r_mem[i] <= r_mem[i+1];
            if (i_push) r_mem[w_wr_idx] <= i_din;
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    end
endmodule

// File: rtl/r512x16_rd_streamer.sv
// r512x16_rd_streamer: burst read sequencer for the 512x16 RAM with a credit-controlled skid FIFO
module r512x16_rd_streamer
    import r512x16_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Cmd_Valid,
    output logic              Cmd_Ready,
    input  logic [ADDR_W-1:0] Cmd_Addr,
    input  logic [LEN_W-1:0]  Cmd_Len,
    output logic [ADDR_W-1:0] RA,
    output logic              RClk_En,
    input  logic [DATA_W-1:0] RD,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Out_Data,
    output logic              Out_Last,
    output logic              Busy,
    output logic              Done
);
    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_rem;
    logic              r_inflight, r_inflight_last, r_done;
    logic [CNT_W-1:0]  w_count;
    logic [DATA_W:0]   w_head;
    logic              w_accept, w_pop, w_last_pop, w_credit;

    assign w_accept   = Cmd_Valid && Cmd_Ready;
    assign Out_Valid  = w_count != '0;
    assign Out_Last   = w_head[DATA_W];
    assign Out_Data   = w_head[DATA_W-1:0];
    assign w_pop      = Out_Valid && Out_Ready;
    assign w_last_pop = w_pop && Out_Last;
    assign w_credit   = has_credit(w_count, r_inflight);
    assign RA         = r_addr;
    assign Done       = r_done;

    // state register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next state and handshake/issue outputs
    always_comb begin
        w_next    = r_state;
        Cmd_Ready = 1'b0;
        Busy      = 1'b1;
        RClk_En   = 1'b0;
        case (r_state)
            IDLE: begin
                Cmd_Ready = 1'b1;
                Busy      = 1'b0;
                w_next    = (Cmd_Valid && Cmd_Len != '0) ? ISSUE : IDLE;
            end
            ISSUE: begin
                RClk_En = w_credit;
                w_next  = (w_credit && r_rem == LEN_W'(1)) ? DRAIN : ISSUE;
            end
            DRAIN:   w_next = w_last_pop ? IDLE : DRAIN;
            default: w_next = IDLE;
        endcase
    end

    // address/remaining counters, read-latency tracking and the completion pulse
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_addr          <= '0;
            r_rem           <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= Cmd_Addr;
                r_rem  <= Cmd_Len;
            end else if (RClk_En) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_rem  <= r_rem - LEN_W'(1);
            end
            r_inflight      <= RClk_En;
            r_inflight_last <= RClk_En && r_rem == LEN_W'(1);
            r_done          <= (w_accept && Cmd_Len == '0) || (r_state == DRAIN && w_last_pop);
        end
    end

    rd_skid_fifo u_fifo (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .i_push  (r_inflight),
        .i_din   ({r_inflight_last, RD}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );
endmodule
